// File: rtl/regfile_writeback.sv
// Write-back front end for the integer register file: arbitrates ALU and load results
// into a small in-order buffer, drains one entry per cycle and forwards pending values.
module regfile_writeback #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_rd,
    input  logic [XLEN-1:0]            alu_data,
    output logic                       alu_ready,
    input  logic                       mem_valid,
    input  logic [AW-1:0]              mem_rd,
    input  logic [XLEN-1:0]            mem_data,
    output logic                       mem_ready,
    input  logic                       rf_stall,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_rd,
    output logic [XLEN-1:0]            rf_wd,
    input  logic [AW-1:0]              byp_rs1,
    input  logic [AW-1:0]              byp_rs2,
    output logic                       byp_hit1,
    output logic [XLEN-1:0]            byp_data1,
    output logic                       byp_hit2,
    output logic [XLEN-1:0]            byp_data2,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {RR_ALU = 1'b0, RR_MEM = 1'b1} rr_e;

    logic [AW-1:0]   buf_rd_q   [DEPTH];
    logic [XLEN-1:0] buf_data_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    rr_e             rr_q, rr_d;

    logic            empty, pop, push, space;
    logic            grant_alu, grant_mem;
    logic [AW-1:0]   enq_rd;
    logic [XLEN-1:0] enq_data;

    // Scans oldest to youngest so a later match overrides an earlier one.
    function automatic logic [XLEN:0] lookup(input logic [AW-1:0] rs);
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q && rs != '0 && buf_rd_q[idx] == rs)
                res = {1'b1, buf_data_q[idx]};
        end
        return res;
    endfunction

    always_comb begin
        empty = (count_q == '0);
        rf_we = !empty && !rf_stall;
        rf_rd = empty ? '0 : buf_rd_q[rd_ptr_q];
        rf_wd = empty ? '0 : buf_data_q[rd_ptr_q];
        pop   = rf_we;

        // Gating with rst keeps producers from seeing an acknowledge while held in reset.
        space     = rst && ((count_q < CW'(DEPTH)) || pop);
        grant_alu = space && alu_valid && (!mem_valid || rr_q == RR_ALU);
        grant_mem = space && mem_valid && (!alu_valid || rr_q == RR_MEM);
        alu_ready = grant_alu;
        mem_ready = grant_mem;

        enq_rd   = grant_mem ? mem_rd : alu_rd;
        enq_data = grant_mem ? mem_data : alu_data;
        push     = (grant_alu || grant_mem) && enq_rd != '0;

        rr_d = rr_q;
        if (space && alu_valid && mem_valid)
            rr_d = (rr_q == RR_ALU) ? RR_MEM : RR_ALU;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        {byp_hit1, byp_data1} = lookup(byp_rs1);
        {byp_hit2, byp_data2} = lookup(byp_rs2);
        count = count_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= RR_ALU;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
        end
    end

    // NOTE: buffer storage is not reset; every read is qualified by count_q, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_rd_q[wr_ptr_q]   <= enq_rd;
            buf_data_q[wr_ptr_q] <= enq_data;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected register-file writes go into a scoreboard
// queue when issued; a negedge monitor compares every rf_we cycle against it.
module tb_regfile_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, rf_stall;
    logic [4:0]  alu_rd, mem_rd, rf_rd, byp_rs1, byp_rs2;
    logic [31:0] alu_data, mem_data, rf_wd, byp_data1, byp_data2;
    logic        alu_ready, mem_ready, rf_we, byp_hit1, byp_hit2;
    logic [2:0]  count;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    regfile_writeback dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_stall(rf_stall), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
        .byp_rs1(byp_rs1), .byp_rs2(byp_rs2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rst && rf_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got rd=%0d wd=%h, required no write", rf_rd, rf_wd);
            end else begin
                e = exp_q.pop_front();
                check("wb_rd", 32'(rf_rd), 32'(e.rd));
                check("wb_wd", rf_wd, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        alu_valid = 0; alu_rd = '0; alu_data = '0;
        mem_valid = 0; mem_rd = '0; mem_data = '0;
        rf_stall = 0; byp_rs1 = '0; byp_rs2 = '0;

        // Reset state
        @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_we", 32'(rf_we), 0);
        check("rst_rd", 32'(rf_rd), 0);
        check("rst_wd", rf_wd, 0);
        check("rst_hit1", 32'(byp_hit1), 0);
        check("rst_data1", byp_data1, 0);
        tick();
        rst = 1'b1;
        tick();

        // Single ALU write, buffer empty: written one cycle after acceptance
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        exp_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
        @(negedge clk);
        check("t1_alu_ready", 32'(alu_ready), 1);
        check("t1_mem_ready", 32'(mem_ready), 0);
        tick();
        alu_valid = 0;
        @(negedge clk);
        check("t1_we_next", 32'(rf_we), 1);
        check("t1_count_next", 32'(count), 1);
        tick();
        @(negedge clk);
        check("t1_we_after", 32'(rf_we), 0);
        check("t1_count_after", 32'(count), 0);
        tick();

        // Fill under stall, fifth push blocked until the first pop
        rf_stall = 1;
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h11 * i;
            exp_q.push_back('{rd: 5'(i), data: 32'h11 * i});
            @(negedge clk);
            check("t2_fill_ready", 32'(alu_ready), 1);
            tick();
        end
        alu_rd = 9; alu_data = 32'h99;
        exp_q.push_back('{rd: 5'd9, data: 32'h99});
        @(negedge clk);
        check("t2_full_count", 32'(count), 4);
        check("t2_full_ready", 32'(alu_ready), 0);
        tick();
        rf_stall = 0;
        @(negedge clk);
        check("t2_pop_ready", 32'(alu_ready), 1);
        check("t2_pop_we", 32'(rf_we), 1);
        tick();
        alu_valid = 0;
        @(negedge clk);
        check("t2_push_pop_count", 32'(count), 4);
        repeat (4) tick();
        @(negedge clk);
        check("t2_drained", 32'(count), 0);
        tick();

        // Contested arbitration: ALU, MEM, ALU, MEM
        alu_valid = 1; alu_rd = 10; alu_data = 32'hA0;
        mem_valid = 1; mem_rd = 11; mem_data = 32'hB0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_alu_ready", 32'(alu_ready), 32'(k % 2 == 0));
            check("t3_mem_ready", 32'(mem_ready), 32'(k % 2 == 1));
            if (k % 2 == 0) exp_q.push_back('{rd: alu_rd, data: alu_data});
            else            exp_q.push_back('{rd: mem_rd, data: mem_data});
            tick();
            if (k % 2 == 0) begin alu_rd = alu_rd + 2; alu_data = alu_data + 1; end
            else            begin mem_rd = mem_rd + 2; mem_data = mem_data + 1; end
        end
        alu_valid = 0; mem_valid = 0;
        repeat (2) tick();

        // Bypass picks the youngest pending entry; rs==0 never hits
        rf_stall = 1;
        byp_rs1 = 7; byp_rs2 = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 32'h1;
        exp_q.push_back('{rd: 5'd7, data: 32'h1});
        @(negedge clk);
        check("t4_no_fwd_incoming", 32'(byp_hit1), 0);
        tick();
        alu_data = 32'h2;
        exp_q.push_back('{rd: 5'd7, data: 32'h2});
        @(negedge clk);
        check("t4_byp_one", byp_data1, 32'h1);
        tick();
        alu_valid = 0;
        @(negedge clk);
        check("t4_hit1", 32'(byp_hit1), 1);
        check("t4_data1", byp_data1, 32'h2);
        check("t4_hit2", 32'(byp_hit2), 0);
        check("t4_data2", byp_data2, 0);
        tick();
        rf_stall = 0;
        repeat (3) tick();
        @(negedge clk);
        check("t4_drained", 32'(count), 0);
        tick();

        // Writes to x0 are acknowledged and dropped
        mem_valid = 1; mem_rd = 0; mem_data = 32'hFFFF;
        @(negedge clk);
        check("t5_mem_ready", 32'(mem_ready), 1);
        tick();
        mem_valid = 0;
        @(negedge clk);
        check("t5_count", 32'(count), 0);
        check("t5_we", 32'(rf_we), 0);
        tick();

        // Reset mid-operation discards pending entries
        rf_stall = 1; byp_rs1 = 20;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1; alu_rd = 5'(20 + k); alu_data = 32'h100 + k;
            @(negedge clk);
            check("t6_fill_ready", 32'(alu_ready), 1);
            tick();
        end
        alu_valid = 0;
        @(negedge clk);
        check("t6_count_pre", 32'(count), 3);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_we", 32'(rf_we), 0);
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_hit1", 32'(byp_hit1), 0);
        rf_stall = 0;
        tick();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_no_stale_we", 32'(rf_we), 0);
        end
        tick();

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
